rr_arb_ctrl: RTL and testbench

//  Round-robin arbiter/controller that shares one downstream resource among N_REQ requesters.
//  A mod-N_REQ priority pointer sets which requester wins next.
//  A hold timer revokes grants that are held too long; a timed-out requester is masked out until it releases.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_ptr_counter.sv | 36 +++
 rtl/rr_arb_ctrl.sv | 137 +++++++++++++
 tb/tb_rr_arb_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the round-robin arbiter.
package arb_pkg;

  // Arbiter controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  // MAX_HOLD value that turns the hold timeout off
  localparam int unsigned HOLD_DISABLED = 0;

  // Ceiling log2 with a floor of 1, so single-value ranges still get a 1-bit field
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_ptr_counter.sv
// Mod-N wrapping counter with synchronous load; holds the arbiter priority pointer.
module rr_ptr_counter
  import arb_pkg::*;
#(
  parameter  int unsigned N = 3,
  localparam int unsigned W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam int unsigned CMP_W = W + 1;

  logic load_oob_c;

  // Out-of-range load values fold to zero so cnt never leaves [0, N-1]
  always_comb begin
    load_oob_c = ({1'b0, load_val} >= CMP_W'(N));
  end

  // Pointer register: load has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_oob_c ? '0 : load_val;
    end else if (inc) begin
      cnt <= (cnt == W'(N - 1)) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter for one shared resource with hold timeout and per-requester timeout mask.
module rr_arb_ctrl
  import arb_pkg::*;
#(
  parameter  int unsigned N_REQ    = 3,
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned PTR_W    = clog2_min1(N_REQ),
  localparam int unsigned HOLD_W   = clog2_min1(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [PTR_W-1:0] gnt_id,
  output logic             timeout_err,
  output logic [PTR_W-1:0] ptr
);

  localparam int unsigned SUM_W      = PTR_W + 1;
  localparam bit          TIMEOUT_EN = (MAX_HOLD != HOLD_DISABLED);
  localparam int unsigned HOLD_LAST  = TIMEOUT_EN ? (MAX_HOLD - 1) : 0;

  arb_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_REQ-1:0]  mask;

  logic [N_REQ-1:0]  elig_c;
  logic [N_REQ-1:0]  rot_c;
  logic [PTR_W-1:0]  off_c;
  logic [SUM_W-1:0]  sum_c;
  logic [PTR_W-1:0]  win_id_c;
  logic [N_REQ-1:0]  win_oh_c;
  logic              grant_now_c;
  logic [PTR_W-1:0]  ptr_nxt_c;
  logic              owner_req_c;
  logic              revoke_c;
  logic [N_REQ-1:0]  mask_nxt_c;

  // Rotate the eligible set so ptr lands at bit 0, then take the lowest set bit
  always_comb begin
    elig_c = req & ~mask;
    rot_c  = N_REQ'({elig_c, elig_c} >> ptr);
    off_c  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot_c[j]) off_c = PTR_W'(j);
    end
  end

  // Map the rotated offset back to a requester index, modulo N_REQ
  always_comb begin
    sum_c    = {1'b0, ptr} + {1'b0, off_c};
    win_id_c = (sum_c >= SUM_W'(N_REQ)) ? PTR_W'(sum_c - SUM_W'(N_REQ)) : PTR_W'(sum_c);
    for (int i = 0; i < N_REQ; i++) begin
      win_oh_c[i] = (win_id_c == PTR_W'(i));
    end
  end

  // Grant decision and the pointer value that follows the winner
  always_comb begin
    grant_now_c = (state == IDLE) && en && (|elig_c);
    ptr_nxt_c   = (win_id_c == PTR_W'(N_REQ - 1)) ? '0 : win_id_c + PTR_W'(1);
  end

  // Owner status; a release seen on the last hold cycle beats the timeout
  always_comb begin
    owner_req_c = |(req & gnt);
    revoke_c    = TIMEOUT_EN && (state == GRANT) && owner_req_c &&
                  (hold_cnt == HOLD_W'(HOLD_LAST));
    mask_nxt_c  = (mask | (revoke_c ? gnt : '0)) & req;
  end

  // Priority pointer; only moves on a grant edge
  rr_ptr_counter #(
    .N (N_REQ)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant_now_c),
    .load_val (ptr_nxt_c),
    .inc      (1'b0),
    .cnt      (ptr)
  );

  // Controller FSM with registered grant, status and mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_vld     <= 1'b0;
      gnt_id      <= '0;
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
      mask        <= '0;
    end else begin
      timeout_err <= 1'b0;
      mask        <= mask_nxt_c;
      case (state)
        IDLE: begin
          if (grant_now_c) begin
            gnt      <= win_oh_c;
            gnt_vld  <= 1'b1;
            gnt_id   <= win_id_c;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req_c) begin
            gnt     <= '0;
            gnt_vld <= 1'b0;
            state   <= RECOVER;
          end else if (revoke_c) begin
            gnt         <= '0;
            gnt_vld     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RECOVER;
          end else if (TIMEOUT_EN) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RECOVER: begin
          gnt     <= '0;
          gnt_vld <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          gnt     <= '0;
          gnt_vld <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Directed self-checking bench for rr_arb_ctrl (N_REQ=3, MAX_HOLD=4).
module tb_rr_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       timeout_err;
  logic [1:0] ptr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arb_ctrl #(
    .N_REQ    (3),
    .MAX_HOLD (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .gnt         (gnt),
    .gnt_vld     (gnt_vld),
    .gnt_id      (gnt_id),
    .timeout_err (timeout_err),
    .ptr         (ptr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample just after the edge, and check grant one-hotness
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  // Wait (bounded) for a grant, then check owner, id and pointer
  task automatic wait_grant(input string tag, input logic [2:0] exp_gnt,
                            input logic [1:0] exp_id, input logic [1:0] exp_ptr);
    int n;
    n = 0;
    while (!gnt_vld && n < 6) begin
      tick();
      n++;
    end
    chk(tag, 32'(gnt), 32'(exp_gnt));
    chk(tag, 32'(gnt_id), 32'(exp_id));
    chk(tag, 32'(ptr), 32'(exp_ptr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] rot_id [4];
    logic [1:0] rot_ptr[4];
    int         n;
    rot_id  = '{2'd0, 2'd1, 2'd2, 2'd0};
    rot_ptr = '{2'd1, 2'd2, 2'd0, 2'd1};

    // 1. reset with all requests asserted
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 3'b111;
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_vld", 32'(gnt_vld), 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_to", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    chk("first_gnt", 32'(gnt), 32'b001);
    chk("first_vld", 32'(gnt_vld), 32'd1);

    // 2. rotation 0,1,2,0 with two dead cycles per handoff
    for (int k = 0; k < 4; k++) begin
      wait_grant("rot", 3'(3'b001 << rot_id[k]), rot_id[k], rot_ptr[k]);
      if (k == 3) req = 3'b000;
      else        req[rot_id[k]] = 1'b0;
      tick();
      chk("rot_dead1", 32'(gnt), 32'd0);
      tick();
      chk("rot_dead2", 32'(gnt), 32'd0);
      if (k != 3) req[rot_id[k]] = 1'b1;
    end

    // 3. pointer skip: bring ptr to 0, then a lone request from 1
    req = 3'b100;
    wait_grant("ptr0", 3'b100, 2'd2, 2'd0);
    req = 3'b000;
    tick();
    tick();
    req = 3'b010;
    tick();
    chk("skip_gnt", 32'(gnt), 32'b010);
    chk("skip_id", 32'(gnt_id), 32'd1);
    chk("skip_ptr", 32'(ptr), 32'd2);
    req = 3'b000;
    tick();
    tick();
    chk("skip_idle_id", 32'(gnt_id), 32'd1);
    req = 3'b001;
    tick();
    chk("wrap_gnt", 32'(gnt), 32'b001);
    chk("wrap_ptr", 32'(ptr), 32'd1);

    // 4. timeout: req[0] held, grant lasts exactly 4 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_hold", 32'(gnt), 32'b001);
      chk("to_noerr", 32'(timeout_err), 32'd0);
    end
    tick();
    chk("to_revoke", 32'(gnt), 32'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_mask", 32'(dut.mask), 32'b001);
    tick();
    chk("to_err_clr", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("to_masked", 32'(gnt), 32'd0);
    end
    req = 3'b000;
    tick();
    chk("to_unmask", 32'(dut.mask), 32'd0);
    req = 3'b001;
    tick();
    chk("to_regnt", 32'(gnt), 32'b001);
    chk("to_regnt_ptr", 32'(ptr), 32'd1);
    req = 3'b000;
    tick();
    tick();

    // 5. en gating, then release on the last hold cycle
    en  = 1'b0;
    req = 3'b100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en_block", 32'(gnt), 32'd0);
    end
    chk("en_block_ptr", 32'(ptr), 32'd1);
    en = 1'b1;
    tick();
    chk("en_gnt", 32'(gnt), 32'b100);
    chk("en_id", 32'(gnt_id), 32'd2);
    chk("en_ptr", 32'(ptr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sim_hold", 32'(gnt), 32'b100);
    end
    req = 3'b000;
    tick();
    chk("sim_rel", 32'(gnt), 32'd0);
    chk("sim_noerr", 32'(timeout_err), 32'd0);
    chk("sim_nomask", 32'(dut.mask), 32'd0);
    tick();
    chk("sim_noerr2", 32'(timeout_err), 32'd0);

    // 6. reset while requester 1 owns the resource and requester 0 is masked
    req = 3'b011;
    wait_grant("r6_g0", 3'b001, 2'd0, 2'd1);
    n = 0;
    while (!timeout_err && n < 8) begin
      tick();
      n++;
    end
    chk("r6_to", 32'(timeout_err), 32'd1);
    wait_grant("r6_g1", 3'b010, 2'd1, 2'd2);
    chk("r6_mask", 32'(dut.mask), 32'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r6_gnt", 32'(gnt), 32'd0);
    chk("r6_vld", 32'(gnt_vld), 32'd0);
    chk("r6_ptr", 32'(ptr), 32'd0);
    chk("r6_mask_clr", 32'(dut.mask), 32'd0);
    chk("r6_id", 32'(gnt_id), 32'd0);
    req = 3'b000;
    #10;
    rst_n = 1'b1;
    tick();
    chk("post_rst", 32'(gnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
